pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the fetch stage. It supports sequential increment, branch load, call and return. Call/return use an internal circular return-address stack (RAS). It holds the PC when stalled and reports stack overflow/underflow to the control unit through sticky status flags.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with increment, branch, call/return and a circular return-address stack.
// Define PC_ALIGN_CHECK_EN to force aligned targets and report misaligned ones on align_err.
module pc_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                INSTR_BYTES = 4,
    parameter int                RAS_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           write_en,
    input  logic                           load,
    input  logic                           call,
    input  logic                           ret,
    input  logic [ADDR_W-1:0]              new_pc,
    output logic [ADDR_W-1:0]              pc_address,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow,
    output logic                           align_err
);

    localparam int                CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int                PTR_W = $clog2(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] stack_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  push_idx;
    logic              push_en;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] top_entry;
    logic [ADDR_W-1:0] target;
    logic              empty;
    logic              full;

    assign ret_addr  = pc_address + STEP;
    assign top_ptr   = sp - PTR_W'(1);
    assign top_entry = stack_mem[top_ptr];
    assign empty     = (ras_count == '0);
    assign full      = (ras_count == CNT_W'(RAS_DEPTH));

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return (addr & LOW_MASK) != '0;
    endfunction

    function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] addr);
        return addr & ~LOW_MASK;
    endfunction

    logic takes_target;
    logic align_err_r;

    assign target       = align_target(new_pc);
    // load only counts when neither call nor ret overrides it
    assign takes_target = call | (ret & empty) | (load & ~ret);

    always_ff @(posedge clk) begin
        if (reset) begin
            align_err_r <= 1'b0;
        end else if (write_en && takes_target && is_misaligned(new_pc)) begin
            align_err_r <= 1'b1;
        end
    end

    assign align_err = align_err_r;
`else
    assign target    = new_pc;
    assign align_err = 1'b0;
`endif

    // A tail-call on a non-empty stack rewrites the top entry instead of pushing.
    always_comb begin
        push_en  = 1'b0;
        push_idx = sp;
        if (write_en && !reset && call) begin
            push_en = 1'b1;
            if (ret && !empty) begin
                push_idx = top_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= ret_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_address    <= RESET_VEC;
            sp            <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (write_en) begin
            if (call && ret) begin
                pc_address <= target;
                if (empty) begin
                    sp        <= sp + PTR_W'(1);
                    ras_count <= CNT_W'(1);
                end
            end else if (ret) begin
                if (empty) begin
                    pc_address    <= target;
                    ras_underflow <= 1'b1;
                end else begin
                    pc_address <= top_entry;
                    sp         <= top_ptr;
                    ras_count  <= ras_count - CNT_W'(1);
                end
            end else if (call) begin
                pc_address <= target;
                sp         <= sp + PTR_W'(1);
                // when full, sp already points at the oldest entry, so the push overwrites it
                if (full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (load) begin
                pc_address <= target;
            end else begin
                pc_address <= ret_addr;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default parameters); align checks follow PC_ALIGN_CHECK_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, write_en, load, call, ret;
    logic [31:0] new_pc;
    logic [31:0] pc_address;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow, align_err;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .write_en(write_en), .load(load), .call(call), .ret(ret),
        .new_pc(new_pc), .pc_address(pc_address), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .align_err(align_err)
    );

    always #5 clk = ~clk;

    // Apply one set of controls for one rising edge, then settle past the edge.
    task automatic step(input logic we, input logic ld, input logic cl, input logic rt,
                        input logic [31:0] npc);
        write_en = we; load = ld; call = cl; ret = rt; new_pc = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        do_reset();
        total++;
        if (pc_address !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_address, 32'h0); end
        total++;
        if ({ras_count, ras_overflow, ras_underflow, align_err} !== 6'b0) begin
            bad++; $display("FAIL reset_state got cnt=%0d ov=%b un=%b al=%b exp all 0",
                            ras_count, ras_overflow, ras_underflow, align_err);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            total++;
            if (pc_address !== exp_pc[i]) begin bad++; $display("FAIL inc_%0d got=%h exp=%h", i, pc_address, exp_pc[i]); end
        end
        total++;
        if ({ras_count, ras_overflow, ras_underflow, align_err} !== 6'b0) begin
            bad++; $display("FAIL inc_state got cnt=%0d ov=%b un=%b exp 0", ras_count, ras_overflow, ras_underflow);
        end
    endtask

    task automatic test_call_ret();
        logic [31:0] exp_pc [4];
        logic [2:0]  exp_cnt [4];
        exp_pc[0] = 32'h800; exp_pc[1] = 32'h804; exp_pc[2] = 32'h808; exp_pc[3] = 32'h104;
        exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd1; exp_cnt[3] = 3'd0;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
        total++;
        if (pc_address !== 32'h100) begin bad++; $display("FAIL load got=%h exp=%h", pc_address, 32'h100); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, (i == 0), (i == 3), 32'h800);
            total++;
            if (pc_address !== exp_pc[i] || ras_count !== exp_cnt[i]) begin
                bad++; $display("FAIL call_ret_%0d got pc=%h cnt=%0d exp pc=%h cnt=%0d",
                                i, pc_address, ras_count, exp_pc[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 32'h10 * (i + 1));
        end
        total++;
        if (ras_overflow !== 1'b1 || ras_count !== 3'd4 || pc_address !== 32'h60) begin
            bad++; $display("FAIL overflow got ov=%b cnt=%0d pc=%h exp ov=1 cnt=4 pc=00000060",
                            ras_overflow, ras_count, pc_address);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
            total++;
            if (pc_address !== exp_ret[i] || ras_count !== 3'(3 - i)) begin
                bad++; $display("FAIL pop_%0d got pc=%h cnt=%0d exp pc=%h cnt=%0d",
                                i, pc_address, ras_count, exp_ret[i], 3 - i);
            end
        end
        total++;
        if (ras_underflow !== 1'b0) begin bad++; $display("FAIL early_underflow got=%b exp=0", ras_underflow); end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h900);
        total++;
        if (pc_address !== 32'h900 || ras_underflow !== 1'b1 || ras_count !== 3'd0 || ras_overflow !== 1'b1) begin
            bad++; $display("FAIL underflow got pc=%h un=%b cnt=%0d ov=%b exp pc=00000900 un=1 cnt=0 ov=1",
                            pc_address, ras_underflow, ras_count, ras_overflow);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'h500);
            total++;
            if (pc_address !== 32'h200 || ras_count !== 3'd0) begin
                bad++; $display("FAIL stall_%0d got pc=%h cnt=%0d exp pc=00000200 cnt=0", i, pc_address, ras_count);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h500);
        total++;
        if (pc_address !== 32'h204 || ras_count !== 3'd0) begin
            bad++; $display("FAIL resume got pc=%h cnt=%0d exp pc=00000204 cnt=0", pc_address, ras_count);
        end
    endtask

    task automatic test_wrap_tailcall();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (pc_address !== 32'h0 || ras_overflow !== 1'b0) begin
            bad++; $display("FAIL wrap got pc=%h ov=%b exp pc=00000000 ov=0", pc_address, ras_overflow);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
        total++;
        if (pc_address !== 32'h40 || ras_count !== 3'd1 || ras_underflow !== 1'b0) begin
            bad++; $display("FAIL tail_empty got pc=%h cnt=%0d un=%b exp pc=00000040 cnt=1 un=0",
                            pc_address, ras_count, ras_underflow);
        end
        // Non-empty tail-call replaces the top (0x4) with 0x44; load must be ignored.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
        total++;
        if (pc_address !== 32'h80 || ras_count !== 3'd1) begin
            bad++; $display("FAIL tail_full got pc=%h cnt=%0d exp pc=00000080 cnt=1", pc_address, ras_count);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h700);
        total++;
        if (pc_address !== 32'h44 || ras_count !== 3'd0 || ras_underflow !== 1'b0) begin
            bad++; $display("FAIL tail_ret got pc=%h cnt=%0d un=%b exp pc=00000044 cnt=0 un=0",
                            pc_address, ras_count, ras_underflow);
        end
    endtask

    task automatic test_reset_midseq_align();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h400);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h500);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h500);
        total++;
        if (ras_count !== 3'd2 || pc_address !== 32'h500) begin
            bad++; $display("FAIL pre_reset got cnt=%0d pc=%h exp cnt=2 pc=00000500", ras_count, pc_address);
        end
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h600);
        reset = 1'b0;
        total++;
        if (pc_address !== 32'h0 || {ras_count, ras_overflow, ras_underflow, align_err} !== 6'b0) begin
            bad++; $display("FAIL midseq_reset got pc=%h cnt=%0d ov=%b un=%b al=%b exp all 0",
                            pc_address, ras_count, ras_overflow, ras_underflow, align_err);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h103);
`ifdef PC_ALIGN_CHECK_EN
        total++;
        if (pc_address !== 32'h100 || align_err !== 1'b1) begin
            bad++; $display("FAIL align got pc=%h al=%b exp pc=00000100 al=1", pc_address, align_err);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (pc_address !== 32'h104 || align_err !== 1'b1) begin
            bad++; $display("FAIL align_sticky got pc=%h al=%b exp pc=00000104 al=1", pc_address, align_err);
        end
`else
        total++;
        if (pc_address !== 32'h103 || align_err !== 1'b0) begin
            bad++; $display("FAIL verbatim_load got pc=%h al=%b exp pc=00000103 al=0", pc_address, align_err);
        end
`endif
    endtask

    initial begin
        reset = 1'b0; write_en = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; new_pc = 32'h0;
        test_reset();
        test_call_ret();
        test_overflow_underflow();
        test_stall();
        test_wrap_tailcall();
        test_reset_midseq_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
